rf_write_arbiter: RTL

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with per-requester FIFOs and a registered write port.
// Define RF_ARB_RR_EN for round-robin arbitration; otherwise B has fixed priority over A.
module rf_write_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic [31:0] pending,
    output logic        busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Index 0 is requester A, index 1 is requester B.
    logic [4:0]    addr_q   [2][DEPTH];
    logic [31:0]   data_q   [2][DEPTH];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] wr_ptr_q [2];
    logic [CW-1:0] count_q  [2];

    logic [4:0]    in_addr  [2];
    logic [31:0]   in_data  [2];
    logic [1:0]    in_valid;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    nonempty;
    logic [1:0]    grant;

    logic          we3_q;
    logic [4:0]    a3_q;
    logic [31:0]   wd3_q;
    logic [31:0]   pending_d;

    assign in_addr[0] = a_addr;
    assign in_addr[1] = b_addr;
    assign in_data[0] = a_data;
    assign in_data[1] = b_data;
    assign in_valid   = {b_valid, a_valid};

    always_comb begin
        ready    = '0;
        push     = '0;
        nonempty = '0;
        for (int i = 0; i < 2; i++) begin
            ready[i]    = count_q[i] != CW'(DEPTH);
            nonempty[i] = count_q[i] != '0;
            // Writes to x0 complete the handshake but are dropped here.
            push[i]     = in_valid[i] && ready[i] && (in_addr[i] != 5'd0);
        end
    end

`ifdef RF_ARB_RR_EN
    logic prio_a_q;

    always_comb begin
        grant = '0;
        if (nonempty[0] && nonempty[1]) begin
            grant = prio_a_q ? 2'b01 : 2'b10;
        end else if (nonempty[0]) begin
            grant = 2'b01;
        end else if (nonempty[1]) begin
            grant = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_a_q <= 1'b1;
        end else if (|grant) begin
            prio_a_q <= grant[1];
        end
    end
`else
    always_comb begin
        grant = '0;
        if (nonempty[1]) begin
            grant = 2'b10;
        end else if (nonempty[0]) begin
            grant = 2'b01;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    addr_q[i][wr_ptr_q[i]] <= in_addr[i];
                    data_q[i][wr_ptr_q[i]] <= in_data[i];
                    wr_ptr_q[i]            <= wr_ptr_q[i] + PW'(1);
                end
                if (grant[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
                end
                if (push[i] && !grant[i]) begin
                    count_q[i] <= count_q[i] + CW'(1);
                end else if (!push[i] && grant[i]) begin
                    count_q[i] <= count_q[i] - CW'(1);
                end
            end
            we3_q <= |grant;
            if (grant[1]) begin
                a3_q  <= addr_q[1][rd_ptr_q[1]];
                wd3_q <= data_q[1][rd_ptr_q[1]];
            end else if (grant[0]) begin
                a3_q  <= addr_q[0][rd_ptr_q[0]];
                wd3_q <= data_q[0][rd_ptr_q[0]];
            end
        end
    end

    // Scoreboard of registers with an outstanding write, queued or on the write port.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (CW'(k) < count_q[i]) begin
                    pending_d[addr_q[i][rd_ptr_q[i] + PW'(k)]] = 1'b1;
                end
            end
        end
        if (we3_q) begin
            pending_d[a3_q] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign a_ready = ready[0];
    assign b_ready = ready[1];
    assign WE3     = we3_q;
    assign A3      = a3_q;
    assign WD3     = wd3_q;
    assign pending = pending_d;
    assign busy    = (|nonempty) | we3_q;

endmodule
